// File: rtl/rip_bp_update_queue_pkg.sv
// rip_branch_predictor_const: shared branch predictor types and constants used by the update queue.
package rip_branch_predictor_const;
    localparam int BP_INDEX_W = 8;
    typedef logic [BP_INDEX_W-1:0] bp_index_t;
    typedef logic [1:0] bp_weight_t;
    localparam bp_weight_t STRONGLY_NOT_TAKEN = 2'd0;
    localparam bp_weight_t WEAKLY_NOT_TAKEN = 2'd1;
    localparam bp_weight_t WEAKLY_TAKEN = 2'd2;
    localparam bp_weight_t STRONGLY_TAKEN = 2'd3;
    localparam int BPQ_DEPTH = 4;
    typedef struct packed {
        bp_index_t index;
        bp_weight_t weight;
        logic pred;
    } bpq_entry_t;
endpackage

// File: rtl/rip_bp_update_queue_if.sv
// rip_bp_update_queue_if: fetch push / execute resolve inputs and predictor update / status outputs.
// slave = queue side, master = pipeline/predictor side.
interface rip_bp_update_queue_if #(parameter int DEPTH = rip_branch_predictor_const::BPQ_DEPTH);
    import rip_branch_predictor_const::*;
    localparam int PTR_W = $clog2(DEPTH);
    logic push;
    bp_index_t push_index;
    bp_weight_t push_weight;
    logic push_pred;
    logic resolve;
    logic resolve_taken;
    logic stall;
    logic flush;
    logic full;
    logic empty;
    logic [PTR_W:0] count;
    logic update;
    bp_index_t update_index;
    bp_weight_t update_weight;
    logic actual;
    logic mispredict;
    logic err_overflow;
    logic err_underflow;
    modport slave (
        input push, push_index, push_weight, push_pred, resolve, resolve_taken, stall, flush,
        output full, empty, count, update, update_index, update_weight, actual, mispredict,
        err_overflow, err_underflow
    );
    modport master (
        output push, push_index, push_weight, push_pred, resolve, resolve_taken, stall, flush,
        input full, empty, count, update, update_index, update_weight, actual, mispredict,
        err_overflow, err_underflow
    );
endinterface

// File: rtl/rip_bpq_storage.sv
// rip_bpq_storage: DEPTH x bpq_entry_t register file, one write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port. Contents are not reset.
module rip_bpq_storage
    import rip_branch_predictor_const::*;
#(
    parameter int DEPTH = BPQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  bpq_entry_t       wdata,
    input  logic [PTR_W-1:0] raddr,
    output bpq_entry_t       rdata
);
    bpq_entry_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/rip_bp_update_queue.sv
// rip_bp_update_queue: in-order queue of branch predictions awaiting resolution; emits registered predictor updates.
// Ports: clk, rstn (async active-low), bus (rip_bp_update_queue_if.slave) carrying push/resolve/stall/flush
// inputs and full/empty/count/update/mispredict/error outputs.
module rip_bp_update_queue
#(
    parameter int DEPTH = rip_branch_predictor_const::BPQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic clk,
    input logic rstn,
    rip_bp_update_queue_if.slave bus
);
    import rip_branch_predictor_const::*;
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0] count;
    logic full, empty, pop_ok, push_ok, flush_ok, overflow_try;
    logic update, actual, mispredict, err_overflow, err_underflow;
    bp_index_t update_index;
    bp_weight_t update_weight;
    bpq_entry_t head, wentry;
    assign full = count == (PTR_W+1)'(DEPTH);
    assign empty = count == '0;
    assign pop_ok = bus.resolve & ~bus.stall & ~empty;
    assign push_ok = bus.push & ~bus.stall & ~bus.flush & (~full | pop_ok);
    assign flush_ok = bus.flush & ~bus.stall;
    // a push discarded by flush is not an overflow; only a genuine full-queue drop is
    assign overflow_try = bus.push & ~bus.stall & ~bus.flush & full & ~pop_ok;
    assign wentry = '{index: bus.push_index, weight: bus.push_weight, pred: bus.push_pred};
    rip_bpq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wptr),
        .wdata (wentry),
        .raddr (rptr),
        .rdata (head)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            update <= 1'b0;
            update_index <= '0;
            update_weight <= '0;
            actual <= 1'b0;
            mispredict <= 1'b0;
            err_overflow <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            update <= pop_ok;
            mispredict <= pop_ok & (head.pred ^ bus.resolve_taken);
            if (pop_ok) begin
                update_index <= head.index;
                update_weight <= head.weight;
                actual <= bus.resolve_taken;
            end
            // the same-cycle pop above still issues its update; flush then clears all state
            if (flush_ok) begin
                wptr <= '0;
                rptr <= '0;
                count <= '0;
            end else begin
                wptr <= wptr + PTR_W'(push_ok);
                rptr <= rptr + PTR_W'(pop_ok);
                count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
            end
            err_overflow <= err_overflow | overflow_try;
            err_underflow <= err_underflow | (bus.resolve & ~bus.stall & empty);
        end
    end
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.count = count;
    assign bus.update = update;
    assign bus.update_index = update_index;
    assign bus.update_weight = update_weight;
    assign bus.actual = actual;
    assign bus.mispredict = mispredict;
    assign bus.err_overflow = err_overflow;
    assign bus.err_underflow = err_underflow;
endmodule

// File: doc/rip_bp_update_queue.md
Name: rip_bp_update_queue

Overview:
- In-order tracking queue between the fetch-side branch predictor and the execute-stage branch resolution.
- Captures each prediction (table index, 2-bit weight, predicted direction) when fetch issues a branch.
- Holds it until execute resolves that branch, then drives a single-cycle registered update toward the predictor's update port and flags mispredictions.
- Also drains on pipeline flush.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- push  input  1  fetch issues a predicted branch this cycle
- push_index  input  bp_index_t  predictor table index used for the prediction
- push_weight  input  bp_weight_t  counter value read at prediction time
- push_pred  input  1  predicted direction (1 = taken)
- resolve  input  1  execute resolves the oldest outstanding branch
- resolve_taken  input  1  actual branch outcome
- stall  input  1  pipeline stall; suppresses resolve and push
- flush  input  1  discard all outstanding entries
- full  output  1  DEPTH entries held
- empty  output  1  no entries held
- count  output  PTR_W+1  occupancy
- update  output  1  registered one-cycle update strobe to the predictor
- update_index  output  bp_index_t  index of the resolved entry
- update_weight  output  bp_weight_t  stored weight of the resolved entry
- actual  output  1  registered resolve_taken
- mispredict  output  1  registered; actual differs from stored prediction
- err_overflow  output  1  sticky: push attempted while full with no pop
- err_underflow  output  1  sticky: resolve attempted while empty

Behaviour:
- Storage is a circular buffer of {index, weight, pred} with a write pointer, a read pointer and a count register (PTR_W+1 bits).
- Pointers wrap modulo DEPTH.
- full = (count == DEPTH); empty = (count == 0); both are combinational from count.
- Reset (async, rstn low): pointers, count, update, update_index, update_weight, actual, mispredict, err_overflow and err_underflow all go to 0; empty=1, full=0. Entry storage need not be reset.
- Effective events: pop_ok = resolve & ~stall & ~empty; push_ok = push & ~stall & ~flush & (~full | pop_ok).
- Pop (pop_ok): on the next edge, update=1; update_index, update_weight and actual come from the head entry and resolve_taken; mispredict = head.pred ^ resolve_taken; read pointer advances. Latency is resolve to update in exactly 1 cycle.
- Without pop_ok, update=0 and mispredict=0 on the next edge. update_index, update_weight and actual hold their last values.
- Stall: no pop, no push, count unchanged, update=0. The predictor therefore never sees update during a stall.
- Push (push_ok): the entry is written at the write pointer, which then advances.
- Simultaneous push and pop: both occur and count is unchanged. This is legal even when full.
- Push while full without pop_ok: the entry is dropped and err_overflow sets.
- Resolve while empty, not stalled: no update is issued and err_underflow sets. A same-cycle push does not bypass to the resolve.
- Errors clear only on reset.
- Flush (not stalled): any same-cycle pop is processed first and its update is issued normally. Then both pointers and count go to 0, and a same-cycle push is ignored. Flush during stall is ignored; upstream holds flush until stall drops.
- Count arithmetic: count_next = count + push_ok - pop_ok, or 0 on flush. This never exceeds DEPTH or goes below 0.
- Reset asserted mid-operation discards all entries; no update is emitted on or after the reset edge.

Decomposition:
- bp_index_t and bp_weight_t come from the existing rip_branch_predictor_const package; add no duplicates.
- Add to rip_branch_predictor_const:
  - BPQ_DEPTH default constant.
  - Packed struct bpq_entry_t {bp_index_t index; bp_weight_t weight; logic pred;}.
- One natural sub-module: rip_bpq_storage, a DEPTH x bpq_entry_t register file with one write port and one asynchronous read port. Pointer, count and update logic stay in the top module.

Test Plan:
- Reset then push {index=0x05, weight=WEAKLY_TAKEN, pred=1}, next cycle resolve_taken=0 -> one cycle later update=1, update_index=0x05, update_weight=WEAKLY_TAKEN, actual=0, mispredict=1; the following cycle update=0 and empty=1.
- Push 4 entries (DEPTH=4) -> full=1, count=4. Push a fifth with resolve=0 -> err_overflow=1, count stays 4. Then push and resolve in the same cycle -> count stays 4, and the update carries the first entry's index.
- Fill 3 entries, then run 6 push/resolve pairs so the pointers wrap -> updates emerge strictly in push order with matching indices and weights.
- Hold resolve=1 with stall=1 for 3 cycles on a non-empty queue -> update stays 0 and count is unchanged. Drop stall -> exactly one update one cycle later.
- With 3 entries, assert resolve and flush in the same cycle along with push -> one update for the head entry, then empty=1 and count=0; the pushed entry is absent. A later resolve -> err_underflow=1, no update.
- Drop rstn asynchronously mid-cycle with 2 entries queued and resolve pending -> all outputs 0 immediately, empty=1, and no update appears after rstn releases.
